mean_square: RTL and testbench

- Windowed mean-of-squares estimator directly upstream of the integer square-root stage; together they form the RMS / magnitude path.
- Takes a stream of signed samples with a valid strobe and squares each one.
- Accumulates 2^LOG2_N consecutive valid squares (block window, non-sliding) and emits the floored mean as an unsigned value.
- Output width is 2*IN_WIDTH, so it connects straight to the sqrt stage's sink with that stage's WIDTH = 2*IN_WIDTH.

---
 rtl/mean_square.sv | 76 +++++++
 tb/tb_mean_square.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/mean_square.sv
// Block-window mean of squared signed samples, feeding the integer sqrt stage (RMS path).
// 3-stage pipeline (capture, square, accumulate); no backpressure, restart flushes the window.
module mean_square #(
  parameter int IN_WIDTH = 16,
  parameter int LOG2_N   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [IN_WIDTH-1:0] sink,
  input  logic                       sink_valid,
  input  logic                       restart,
  output logic [2*IN_WIDTH-1:0]      source,
  output logic                       source_valid
);

  localparam int OW = 2 * IN_WIDTH;
  localparam int AW = OW + LOG2_N;
  localparam int CW = (LOG2_N > 0) ? LOG2_N : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((64'd1 << LOG2_N) - 64'd1);

  logic signed [IN_WIDTH-1:0] s1_dat;
  logic                       s1_vld;
  logic [OW-1:0]              s2_sq;
  logic                       s2_vld;
  logic [AW-1:0]              acc;
  logic [CW-1:0]              count;

  logic signed [OW-1:0]       prod;
  logic [AW-1:0]              sum;
  logic                       last;

  // Square of the most negative sample is +2^(OW-2), still positive in OW signed bits.
  assign prod = s1_dat * s1_dat;
  assign sum  = acc + AW'(s2_sq);
  assign last = (count == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_dat       <= '0;
      s1_vld       <= 1'b0;
      s2_sq        <= '0;
      s2_vld       <= 1'b0;
      acc          <= '0;
      count        <= '0;
      source       <= '0;
      source_valid <= 1'b0;
    end else begin
      // The sample presented alongside restart survives and opens the new window.
      s1_dat <= sink;
      s1_vld <= sink_valid;
      s2_sq  <= unsigned'(prod);
      if (restart) begin
        s2_vld       <= 1'b0;
        acc          <= '0;
        count        <= '0;
        source_valid <= 1'b0;
      end else begin
        s2_vld       <= s1_vld;
        source_valid <= 1'b0;
        if (s2_vld) begin
          if (last) begin
            // Upper OW bits of the full sum are the floored mean.
            source       <= sum[LOG2_N +: OW];
            source_valid <= 1'b1;
            acc          <= '0;
            count        <= '0;
          end else begin
            acc   <= sum;
            count <= count + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mean_square.sv
// Directed bench for mean_square with IN_WIDTH=16, LOG2_N=2 (window of 4).
module tb_mean_square;

  localparam int IW = 16;
  localparam int LN = 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic signed [IW-1:0] sink = '0;
  logic                 sink_valid = 1'b0;
  logic                 restart = 1'b0;
  logic [2*IW-1:0]      source;
  logic                 source_valid;

  int cyc = 0;
  int total = 0;
  int passed = 0;
  int pulse_cyc[$];
  logic [2*IW-1:0] pulse_val[$];

  mean_square #(.IN_WIDTH(IW), .LOG2_N(LN)) dut (
    .clk(clk), .rst(rst), .sink(sink), .sink_valid(sink_valid),
    .restart(restart), .source(source), .source_valid(source_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (source_valid) begin
      pulse_cyc.push_back(cyc);
      pulse_val.push_back(source);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    else passed++;
  endtask

  // Present one input for the current cycle, then move to the next cycle.
  task automatic send(input logic signed [IW-1:0] v, input logic vld, input logic rs);
    sink = v; sink_valid = vld; restart = rs;
    @(posedge clk); #1;
    sink_valid = 1'b0; restart = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send('0, 1'b0, 1'b0);
  endtask

  task automatic clear_log();
    pulse_cyc.delete();
    pulse_val.delete();
  endtask

  int k;
  logic signed [IW-1:0] vec[4];

  initial begin
    #2;
    check("reset_source", source, 0);
    check("reset_valid", source_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Consecutive 3,-4,5,-6: 86/4 -> 21, pulse 3 cycles after the 4th sample
    vec = '{16'sd3, -16'sd4, 16'sd5, -16'sd6};
    clear_log();
    for (int i = 0; i < 4; i++) begin
      k = cyc;
      send(vec[i], 1'b1, 1'b0);
    end
    idle(6);
    check("basic_npulse", pulse_cyc.size(), 1);
    if (pulse_cyc.size() == 1) begin
      check("basic_latency", pulse_cyc[0], k + 3);
      check("basic_value", pulse_val[0], 21);
    end
    check("basic_hold", source, 21);

    // Extremes
    clear_log();
    for (int i = 0; i < 4; i++) send(-16'sd32768, 1'b1, 1'b0);
    idle(5);
    for (int i = 0; i < 4; i++) send(16'sd32767, 1'b1, 1'b0);
    idle(5);
    check("ext_npulse", pulse_cyc.size(), 2);
    if (pulse_cyc.size() == 2) begin
      check("ext_neg", pulse_val[0], 64'h4000_0000);
      check("ext_pos", pulse_val[1], 64'h3FFF_0001);
    end

    // Gapped stream
    clear_log();
    for (int i = 0; i < 4; i++) begin
      k = cyc;
      send(vec[i], 1'b1, 1'b0);
      if (i < 3) idle(2);
    end
    idle(5);
    check("gap_npulse", pulse_cyc.size(), 1);
    if (pulse_cyc.size() == 1) begin
      check("gap_latency", pulse_cyc[0], k + 3);
      check("gap_value", pulse_val[0], 21);
    end

    // Restart discards the 100s; the sample sent with restart is sample 1
    clear_log();
    send(16'sd100, 1'b1, 1'b0);
    send(16'sd100, 1'b1, 1'b0);
    send(16'sd1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) send(16'sd1, 1'b1, 1'b0);
    idle(6);
    check("rst_npulse", pulse_cyc.size(), 1);
    if (pulse_cyc.size() == 1) check("rst_value", pulse_val[0], 1);

    // Restart on the completing edge suppresses the pulse
    clear_log();
    for (int i = 0; i < 4; i++) send(16'sd8, 1'b1, 1'b0);
    idle(1);
    send('0, 1'b0, 1'b1);
    idle(5);
    check("supp_npulse", pulse_cyc.size(), 0);
    check("supp_hold", source, 1);

    // Continuous 8 x 2 -> two pulses 4 apart, each 4
    clear_log();
    for (int i = 0; i < 8; i++) send(16'sd2, 1'b1, 1'b0);
    check("cont_mid_hold", source, 4);
    idle(5);
    check("cont_npulse", pulse_cyc.size(), 2);
    if (pulse_cyc.size() == 2) begin
      check("cont_spacing", pulse_cyc[1] - pulse_cyc[0], 4);
      check("cont_val0", pulse_val[0], 4);
      check("cont_val1", pulse_val[1], 4);
    end

    // Async reset mid-window, then a fresh window of 10s
    send(16'sd50, 1'b1, 1'b0);
    send(16'sd50, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("arst_source", source, 0);
    check("arst_valid", source_valid, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_log();
    for (int i = 0; i < 3; i++) send(16'sd10, 1'b1, 1'b0);
    idle(5);
    check("arst_no_early", pulse_cyc.size(), 0);
    send(16'sd10, 1'b1, 1'b0);
    idle(5);
    check("arst_npulse", pulse_cyc.size(), 1);
    if (pulse_cyc.size() == 1) check("arst_value", pulse_val[0], 100);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
